// File: rtl/cache_mem_bridge_pkg.sv
// Shared types and constants for the cache-to-memory bridge.
// FSM state codes, grant encodings and the fixed word transfer size.
package cache_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational grant choice between inst and data cache requests.
// On a collision the port that was not granted last wins.
module cache_arb_pick
  import cache_mem_bridge_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  output logic grant
);

  always_comb begin
    grant = GRANT_DATA;
    unique case (1'b1)
      (inst_req && data_req): begin
        grant = (last_grant == GRANT_DATA) ?
                GRANT_INST : GRANT_DATA;
      end
      (inst_req && !data_req): grant = GRANT_INST;
      default:                 grant = GRANT_DATA;
    endcase
  end

endmodule

// File: rtl/cache_mem_bridge.sv
// Inst/data cache miss bridge onto an addr_ok/data_ok memory bus.
// Define CACHE_ARB_RR_EN for round-robin; default is data-over-inst.
module cache_mem_bridge
  import cache_mem_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_cache_req,
  input  logic [ADDR_W-1:0] inst_cache_addr,
  output logic [DATA_W-1:0] inst_cache_rdata,
  output logic              inst_cache_dok,
  input  logic              data_cache_req,
  input  logic              data_cache_wr,
  input  logic [ADDR_W-1:0] data_cache_addr,
  input  logic [DATA_W-1:0] data_cache_wdata,
  output logic [DATA_W-1:0] data_cache_rdata,
  output logic              data_cache_dok,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_ok
);

  state_e            state_q;
  logic              grant_q;
  logic              wr_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              inst_dok_q;
  logic              data_dok_q;
  logic              grant_d;
  logic              last_grant;
  logic              any_req;

  assign any_req = inst_cache_req | data_cache_req;

`ifdef CACHE_ARB_RR_EN
  logic last_grant_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= GRANT_INST;
    end else if (state_q == ST_IDLE && any_req) begin
      last_grant_q <= grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  // Pinning last_grant to inst makes every collision go to data.
  assign last_grant = GRANT_INST;
`endif

  cache_arb_pick u_arb (
    .inst_req   (inst_cache_req),
    .data_req   (data_cache_req),
    .last_grant (last_grant),
    .grant      (grant_d)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= GRANT_INST;
      wr_q         <= 1'b0;
      mem_req_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_dok_q   <= 1'b0;
      data_dok_q   <= 1'b0;
    end else begin
      inst_dok_q <= 1'b0;
      data_dok_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q   <= grant_d;
            mem_req_q <= 1'b1;
            state_q   <= ST_ADDR;
            if (grant_d == GRANT_DATA) begin
              addr_q  <= data_cache_addr;
              wr_q    <= data_cache_wr;
              wdata_q <= data_cache_wdata;
            end else begin
              addr_q  <= inst_cache_addr;
              wr_q    <= 1'b0;
              wdata_q <= '0;
            end
          end
        end
        ST_ADDR: begin
          if (mem_addr_ok) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_data_ok) begin
            state_q <= ST_RESP;
            if (grant_q == GRANT_DATA) begin
              data_dok_q <= 1'b1;
              if (!wr_q) data_rdata_q <= mem_rdata;
            end else begin
              inst_dok_q <= 1'b1;
              if (!wr_q) inst_rdata_q <= mem_rdata;
            end
          end
        end
        // One dead cycle so a req dropped on dok is not re-granted.
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_wr           = wr_q;
  assign mem_size         = MEM_SIZE_WORD;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign inst_cache_rdata = inst_rdata_q;
  assign inst_cache_dok   = inst_dok_q;
  assign data_cache_rdata = data_rdata_q;
  assign data_cache_dok   = data_dok_q;

endmodule
